// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shift sequencer.
package shift_pkg;

  localparam int SHIFT_MAX_AMT = 32;

  typedef enum logic [1:0] {
    SHIFT_LEFT             = 2'd0,
    SHIFT_RIGHT_LOGICAL    = 2'd1,
    SHIFT_RIGHT_ARITHMETIC = 2'd2,
    SHIFT_RESERVED         = 2'd3
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step: 32 bits by 0..STEP with op-dependent fill.
module shift_step
  import shift_pkg::*;
#(
  parameter int STEP = 4,
  parameter int AW   = $clog2(STEP + 1)
) (
  input  logic [31:0]   i_a,
  input  logic [AW-1:0] i_amt,
  input  logic [1:0]    i_op,
  output logic [31:0]   o_y
);

  // Arithmetic right keeps replicating bit 31, so the latched sign survives every step.
  always_comb begin
    o_y = i_a;
    case (i_op)
      SHIFT_LEFT:             o_y = i_a << i_amt;
      SHIFT_RIGHT_LOGICAL:    o_y = i_a >> i_amt;
      SHIFT_RIGHT_ARITHMETIC: o_y = 32'($signed(i_a) >>> i_amt);
      default:                o_y = i_a;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shifter: consumes up to STEP bits of the shift amount per clock.
// Optional macro SHIFT_EARLY_EXIT_EN: leave SHIFT as soon as the working value
// already equals its fill pattern (same result, shorter latency).
module shift_sequencer
  import shift_pkg::*;
#(
  parameter int STEP  = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       shift_op,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int AW = $clog2(STEP + 1);

  state_e      r_state, w_next;
  logic [5:0]  r_rem;
  logic [1:0]  r_op;
  logic [31:0] r_work, r_result;
  logic [5:0]  w_sat;
  logic [AW-1:0] w_amt;
  logic [31:0] w_shifted;
  logic        w_accept, w_last;

  // Any amount with a bit at or above bit 5 set is >= 32 and saturates.
  assign w_sat    = (|in_b[31:5]) ? 6'(SHIFT_MAX_AMT) : {1'b0, in_b[4:0]};
  assign w_accept = (r_state == IDLE) && start && !abort;
  assign w_amt    = (r_rem < 6'(STEP)) ? r_rem[AW-1:0] : AW'(STEP);
  assign w_last   = (r_rem <= 6'(STEP));

`ifdef SHIFT_EARLY_EXIT_EN
  logic w_fill_match;
  assign w_fill_match = (r_op == SHIFT_RIGHT_ARITHMETIC) ? (r_work == {32{r_work[31]}})
                                                         : (r_work == 32'd0);
`endif

  shift_step #(.STEP(STEP), .AW(AW)) u_step (
    .i_a   (r_work),
    .i_amt (w_amt),
    .i_op  (r_op),
    .o_y   (w_shifted)
  );

  // Next-state: abort wins everywhere outside IDLE; DONE always lasts one cycle.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept)
          w_next = (w_sat == 6'd0 || shift_op == SHIFT_RESERVED) ? DONE : SHIFT;
      end
      SHIFT: begin
        if (abort)       w_next = IDLE;
        else if (w_last) w_next = DONE;
`ifdef SHIFT_EARLY_EXIT_EN
        else if (w_fill_match) w_next = DONE;
`endif
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State, working register, remaining count and committed result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_rem    <= 6'd0;
      r_op     <= 2'd0;
      r_work   <= 32'd0;
      r_result <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_work <= in_a;
        r_op   <= shift_op;
        r_rem  <= w_sat;
      end else if (r_state == SHIFT) begin
        r_work <= w_shifted;
        r_rem  <= r_rem - 6'(w_amt);
      end
      // Commit only a completed, non-aborted operation so the held value survives aborts.
      if (r_state == DONE && !abort)
        r_result <= r_work;
    end
  end

  assign busy   = (r_state == SHIFT);
  assign done   = (r_state == DONE) && !abort;
  assign result = done ? r_work : r_result;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: behavioural latency/result model plus directed literal checks.
module tb_shift_sequencer;

  localparam int STEP = 4;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        start = 0;
  logic [31:0] in_a = 0;
  logic [31:0] in_b = 0;
  logic [1:0]  shift_op = 0;
  logic        abort = 0;
  logic        busy, done;
  logic [31:0] result;

  int vec = 0;
  int errs = 0;

  shift_sequencer #(.STEP(STEP), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_a(in_a), .in_b(in_b),
    .shift_op(shift_op), .abort(abort), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Reference result straight from the shift semantics.
  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    int amt;
    amt = (b >= 32) ? 32 : int'(b);
    case (op)
      2'd0:    return (amt >= 32) ? 32'd0 : (a << amt);
      2'd1:    return (amt >= 32) ? 32'd0 : (a >> amt);
      2'd2:    return (amt >= 32) ? {32{a[31]}} : 32'($signed(a) >>> amt);
      default: return a;
    endcase
  endfunction

  // Cycles from accepting edge until done is visible.
  function automatic int ref_lat(input logic [31:0] a, input logic [31:0] b,
                                 input logic [1:0] op);
    int amt, n;
    logic [31:0] fill;
    amt = (b >= 32) ? 32 : int'(b);
    if (amt == 0 || op == 2'd3) return 1;
    n = (amt + STEP - 1) / STEP;
    fill = (op == 2'd2) ? {32{a[31]}} : 32'd0;
`ifdef SHIFT_EARLY_EXIT_EN
    for (int i = 1; i < n; i++)
      if (ref_shift(a, 32'((i - 1) * STEP), op) == fill) return i + 1;
`else
    if (fill == 32'd1) return 0;  // never: fill is 0 or all ones
`endif
    return n + 1;
  endfunction

  // Model: countdown to done plus committed/pending result.
  int          m_left;
  logic [31:0] m_pend, m_result;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_pend <= 0; m_result <= 0;
    end else if (m_left == 0) begin
      if (start && !abort) begin
        m_left <= ref_lat(in_a, in_b, shift_op);
        m_pend <= ref_shift(in_a, in_b, shift_op);
      end
    end else if (abort) begin
      m_left <= 0;
    end else begin
      if (m_left == 1) m_result <= m_pend;
      m_left <= m_left - 1;
    end
  end

  // Compare process: every falling edge, all outputs against the model.
  always @(negedge clk) begin
    logic e_done, e_busy;
    logic [31:0] e_res;
    e_done = (m_left == 1) && !abort;
    e_busy = (m_left > 1);
    e_res  = e_done ? m_pend : m_result;
    vec++;
    if (busy !== e_busy || done !== e_done || result !== e_res) begin
      errs++;
      $display("FAIL model t=%0t busy=%b/%b done=%b/%b result=%h/%h (got/exp)",
               $time, busy, e_busy, done, e_done, result, e_res);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Directed op: returns observed latency, busy cycles and final result.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] er, input int el,
                        output int nbusy);
    int lat;
    @(posedge clk); #1;
    start = 1; in_a = a; in_b = b; shift_op = op;
    @(posedge clk); #1;
    start = 0; in_a = $urandom; in_b = $urandom;
    lat = 1; nbusy = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      @(posedge clk); #1;
      lat++;
    end
    chk({name, "_done_seen"}, 32'(done), 32'd1);
    chk({name, "_result"}, result, er);
    chk({name, "_latency"}, 32'(lat), 32'(el));
  endtask

  int nb;
  int lat_ee;

  initial begin
    #12;
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    chk("reset_result", result, 0);
    rst_n = 1;

    // model pinned against hand-computed literals
    chk("ref_left5", ref_shift(32'h1, 5, 0), 32'h20);
    chk("ref_lat_left5", 32'(ref_lat(32'h1, 5, 0)), 3);
    chk("ref_asr_sat", ref_shift(32'hDEADBEEF, 40, 2), 32'hFFFFFFFF);

    run_op("left5", 32'h1, 5, 0, 32'h20, 3, nb);
    chk("left5_busy_cycles", 32'(nb), 2);
    run_op("asr31", 32'h80000000, 31, 2, 32'hFFFFFFFF, 9, nb);
    run_op("lsr31", 32'h80000000, 31, 1, 32'h1, 9, nb);
    run_op("sat256", 32'hDEADBEEF, 32'h100, 1, 32'h0, 9, nb);
    run_op("sat32", 32'hDEADBEEF, 32, 1, 32'h0, 9, nb);
    run_op("asr40", 32'hDEADBEEF, 40, 2, 32'hFFFFFFFF, 9, nb);
    run_op("zero", 32'h12345678, 0, 0, 32'h12345678, 1, nb);
    run_op("resv", 32'h12345678, 7, 3, 32'h12345678, 1, nb);
`ifdef SHIFT_EARLY_EXIT_EN
    lat_ee = 4;
`else
    lat_ee = 9;
`endif
    run_op("early", 32'h10, 32, 1, 32'h0, lat_ee, nb);
    run_op("upper", 32'h1, 32'h8000_0001, 0, 32'h0, 9, nb);

    // second start while busy is ignored
    @(posedge clk); #1;
    start = 1; in_a = 32'h1; in_b = 8; shift_op = 0;
    @(posedge clk); #1;
    start = 1; in_a = 32'hFFFF; in_b = 0; shift_op = 3;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 10 && !done; i++) begin @(posedge clk); #1; end
    chk("busy_start_result", result, 32'h100);
    @(posedge clk); #1;

    // abort at cycle 2 of a 32-bit shift: result keeps 0x100
    start = 1; in_a = 32'hFFFFFFFF; in_b = 32; shift_op = 1;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) nb++;
      @(posedge clk); #1;
    end
    chk("abort_no_activity", 32'(nb), 0);
    chk("abort_result_kept", result, 32'h100);

    // async reset mid-SHIFT
    start = 1; in_a = 32'h55; in_b = 32; shift_op = 0;
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", result, 0);
    @(negedge clk); #2;
    rst_n = 1;

    // random traffic, checked every cycle by the compare process
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 2) == 0);
      abort = ($urandom_range(0, 19) == 0);
      in_a = $urandom;
      case ($urandom_range(0, 3))
        0:       in_b = $urandom;
        1:       in_b = 32'($urandom_range(28, 40));
        default: in_b = 32'($urandom_range(0, 12));
      endcase
      shift_op = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    start = 0; abort = 0;
    repeat (12) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
